// File: rtl/bus_pkg.sv
// Shared definitions for the bus generator/arbiter device ports.
package bus_pkg;

  localparam int unsigned ID_W         = 8;
  localparam logic [7:0]  BROADCAST_ID = 8'hFF;
  localparam int unsigned PKT_W_MAX    = 64;

  // Destination ID sits in the top ID_W bits of a packet of width sz.
  function automatic logic [ID_W-1:0] get_dest(input logic [PKT_W_MAX-1:0] pkt,
                                               input int unsigned           sz);
    return ID_W'(pkt >> (sz - ID_W));
  endfunction

endpackage

// File: rtl/bus_sync_fifo.sv
// First-word-fall-through synchronous FIFO with overflow/underflow event pulses.
module bus_sync_fifo #(
  parameter int unsigned width = 16,
  parameter int unsigned depth = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr,
  input  logic [width-1:0]             wdata,
  input  logic                         rd,
  output logic [width-1:0]             rdata,
  output logic [$clog2(depth+1)-1:0]   count,
  output logic                         full,
  output logic                         empty,
  output logic                         ovf_evt,
  output logic                         udf_evt
);

  localparam int unsigned PW = $clog2(depth);
  localparam int unsigned CW = $clog2(depth+1);

  logic [width-1:0] mem [depth];
  logic [PW-1:0]    wptr, rptr;
  logic [CW-1:0]    cnt;
  logic             do_wr, do_rd;

  assign empty = (cnt == CW'(0));
  assign full  = (cnt == CW'(depth));
  assign count = cnt;

  // A write into a full FIFO is only accepted when a real read frees a slot.
  assign do_rd   = rd && !empty;
  assign do_wr   = wr && (!full || do_rd);
  assign ovf_evt = wr && full && !do_rd;
  assign udf_evt = rd && empty;

  assign rdata = empty ? '0 : mem[rptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_wr) wptr <= wptr + PW'(1);
      if (do_rd) rptr <= rptr + PW'(1);
      if (do_wr && !do_rd)      cnt <= cnt + CW'(1);
      else if (do_rd && !do_wr) cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/bus_dev_port.sv
// Per-device adapter: TX FIFO toward the arbiter, RX FIFO from it, sticky status.
module bus_dev_port
  import bus_pkg::*;
#(
  parameter int unsigned pckg_sz   = 16,
  parameter int unsigned depth     = 8,
  parameter logic [7:0]  id        = 8'd0,
  parameter logic [7:0]  broadcast = BROADCAST_ID
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       tx_push,
  input  logic [pckg_sz-1:0]         tx_data,
  output logic                       tx_full,
  output logic [$clog2(depth+1)-1:0] tx_count,
  output logic                       pndng,
  output logic [pckg_sz-1:0]         D_pop,
  input  logic                       pop,
  input  logic                       push,
  input  logic [pckg_sz-1:0]         D_push,
  input  logic                       rx_pop,
  output logic [pckg_sz-1:0]         rx_data,
  output logic                       rx_empty,
  output logic [$clog2(depth+1)-1:0] rx_count,
  input  logic                       clr_flags,
  output logic                       tx_ovf,
  output logic                       rx_ovf,
  output logic                       underflow,
  output logic                       rx_misdir
);

  logic              tx_empty, rx_full;
  logic              tx_ovf_evt, tx_udf_evt, rx_ovf_evt, rx_udf_evt;
  logic              misdir_evt;
  logic [ID_W-1:0]   rx_dest;

  bus_sync_fifo #(.width(pckg_sz), .depth(depth)) u_tx_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr      (tx_push),
    .wdata   (tx_data),
    .rd      (pop),
    .rdata   (D_pop),
    .count   (tx_count),
    .full    (tx_full),
    .empty   (tx_empty),
    .ovf_evt (tx_ovf_evt),
    .udf_evt (tx_udf_evt)
  );

  bus_sync_fifo #(.width(pckg_sz), .depth(depth)) u_rx_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr      (push),
    .wdata   (D_push),
    .rd      (rx_pop),
    .rdata   (rx_data),
    .count   (rx_count),
    .full    (rx_full),
    .empty   (rx_empty),
    .ovf_evt (rx_ovf_evt),
    .udf_evt (rx_udf_evt)
  );

  assign pndng = !tx_empty;

  // Misdirected deliveries are still stored; they only raise the flag.
  assign rx_dest    = get_dest(PKT_W_MAX'(D_push), pckg_sz);
  assign misdir_evt = push && (rx_dest != id) && (rx_dest != broadcast);

  // Sticky flags: a new event in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_ovf    <= 1'b0;
      rx_ovf    <= 1'b0;
      underflow <= 1'b0;
      rx_misdir <= 1'b0;
    end else begin
      tx_ovf    <= tx_ovf_evt | (tx_ovf & ~clr_flags);
      rx_ovf    <= (rx_ovf_evt & !rx_full) | (rx_ovf_evt & rx_full) | (rx_ovf & ~clr_flags);
      underflow <= tx_udf_evt | rx_udf_evt | (underflow & ~clr_flags);
      rx_misdir <= misdir_evt | (rx_misdir & ~clr_flags);
    end
  end

endmodule

// File: tb/tb_bus_dev_port.sv
// Scoreboard bench for bus_dev_port: queues hold expected TX/RX packet order.
module tb_bus_dev_port;

  localparam int unsigned PSZ = 16;
  localparam int unsigned DEP = 8;
  localparam logic [7:0]  MY_ID = 8'd2;

  logic           clk, reset;
  logic           tx_push, pop, push, rx_pop, clr_flags;
  logic [PSZ-1:0] tx_data, D_push, D_pop, rx_data;
  logic           tx_full, pndng, rx_empty;
  logic [3:0]     tx_count, rx_count;
  logic           tx_ovf, rx_ovf, underflow, rx_misdir;

  int total = 0;
  int bad   = 0;
  logic [PSZ-1:0] txq[$];
  logic [PSZ-1:0] rxq[$];

  bus_dev_port #(.pckg_sz(PSZ), .depth(DEP), .id(MY_ID), .broadcast(8'hFF)) dut (
    .clk(clk), .reset(reset),
    .tx_push(tx_push), .tx_data(tx_data), .tx_full(tx_full), .tx_count(tx_count),
    .pndng(pndng), .D_pop(D_pop), .pop(pop),
    .push(push), .D_push(D_push),
    .rx_pop(rx_pop), .rx_data(rx_data), .rx_empty(rx_empty), .rx_count(rx_count),
    .clr_flags(clr_flags),
    .tx_ovf(tx_ovf), .rx_ovf(rx_ovf), .underflow(underflow), .rx_misdir(rx_misdir)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    tx_push = 0; pop = 0; push = 0; rx_pop = 0; clr_flags = 0;
    tx_data = '0; D_push = '0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b0;
    #12;
    total++; if (pndng !== 1'b0)    begin bad++; $display("FAIL reset_pndng got=%b want=0", pndng); end
    total++; if (tx_full !== 1'b0)  begin bad++; $display("FAIL reset_tx_full got=%b want=0", tx_full); end
    total++; if (rx_empty !== 1'b1) begin bad++; $display("FAIL reset_rx_empty got=%b want=1", rx_empty); end
    total++; if (tx_count !== 4'd0 || rx_count !== 4'd0)
      begin bad++; $display("FAIL reset_counts got=%0d/%0d want=0/0", tx_count, rx_count); end
    total++; if ({tx_ovf, rx_ovf, underflow, rx_misdir} !== 4'b0000)
      begin bad++; $display("FAIL reset_flags got=%b want=0000", {tx_ovf, rx_ovf, underflow, rx_misdir}); end
    total++; if (D_pop !== 16'h0 || rx_data !== 16'h0)
      begin bad++; $display("FAIL reset_data got=%h/%h want=0000/0000", D_pop, rx_data); end
    @(negedge clk);
    reset = 1'b1;
    step();
  endtask

  task automatic test_tx_basic();
    logic [PSZ-1:0] pk [3];
    logic [PSZ-1:0] exp;
    pk[0] = 16'h0155; pk[1] = 16'h0256; pk[2] = 16'h0357;
    for (int i = 0; i < 3; i++) begin
      tx_push = 1; tx_data = pk[i]; txq.push_back(pk[i]);
      step();
      if (i == 0) begin
        tx_push = 0;
        total++; if (pndng !== 1'b1 || D_pop !== 16'h0155)
          begin bad++; $display("FAIL tx_latency got pndng=%b D_pop=%h want 1/0155", pndng, D_pop); end
      end
    end
    tx_push = 0;
    total++; if (tx_count !== 4'd3) begin bad++; $display("FAIL tx_count3 got=%0d want=3", tx_count); end
    for (int i = 0; i < 3; i++) begin
      exp = txq.pop_front();
      total++; if (D_pop !== exp) begin bad++; $display("FAIL tx_order%0d got=%h want=%h", i, D_pop, exp); end
      pop = 1; step(); pop = 0;
    end
    total++; if (pndng !== 1'b0) begin bad++; $display("FAIL tx_drained_pndng got=%b want=0", pndng); end
  endtask

  task automatic test_tx_overflow();
    logic [PSZ-1:0] exp;
    for (int i = 0; i < 9; i++) begin
      tx_push = 1; tx_data = 16'h1000 + PSZ'(i);
      if (txq.size() < DEP) txq.push_back(tx_data);
      step();
      if (i == 7) begin
        total++; if (tx_full !== 1'b1 || tx_ovf !== 1'b0)
          begin bad++; $display("FAIL tx_full8 got full=%b ovf=%b want 1/0", tx_full, tx_ovf); end
      end
    end
    tx_push = 0;
    total++; if (tx_ovf !== 1'b1 || tx_count !== 4'd8)
      begin bad++; $display("FAIL tx_ovf9 got ovf=%b cnt=%0d want 1/8", tx_ovf, tx_count); end
    // Push and pop together while full: accepted, count steady, flag unchanged.
    exp = txq.pop_front();
    total++; if (D_pop !== exp) begin bad++; $display("FAIL tx_full_head got=%h want=%h", D_pop, exp); end
    tx_push = 1; pop = 1; tx_data = 16'h1ABC; txq.push_back(16'h1ABC);
    step();
    tx_push = 0; pop = 0;
    total++; if (tx_count !== 4'd8 || tx_ovf !== 1'b1)
      begin bad++; $display("FAIL tx_full_rw got cnt=%0d ovf=%b want 8/1", tx_count, tx_ovf); end
    while (txq.size() > 0) begin
      exp = txq.pop_front();
      total++; if (D_pop !== exp) begin bad++; $display("FAIL tx_ovf_drain got=%h want=%h", D_pop, exp); end
      pop = 1; step(); pop = 0;
    end
    clr_flags = 1; step(); clr_flags = 0;
    total++; if (tx_ovf !== 1'b0) begin bad++; $display("FAIL tx_ovf_clr got=%b want=0", tx_ovf); end
  endtask

  task automatic test_rx_misdir();
    logic [PSZ-1:0] pk [3];
    logic [PSZ-1:0] exp;
    logic           want_md;
    pk[0] = 16'h02AA; pk[1] = 16'hFF11; pk[2] = 16'h0533;
    for (int i = 0; i < 3; i++) begin
      push = 1; D_push = pk[i]; rxq.push_back(pk[i]);
      step();
      want_md = (i == 2);
      total++; if (rx_misdir !== want_md)
        begin bad++; $display("FAIL rx_misdir%0d got=%b want=%b", i, rx_misdir, want_md); end
    end
    push = 0;
    total++; if (rx_count !== 4'd3 || rx_empty !== 1'b0)
      begin bad++; $display("FAIL rx_count3 got cnt=%0d empty=%b want 3/0", rx_count, rx_empty); end
    clr_flags = 1; step(); clr_flags = 0;
    total++; if (rx_misdir !== 1'b0) begin bad++; $display("FAIL rx_misdir_clr got=%b want=0", rx_misdir); end
    while (rxq.size() > 0) begin
      exp = rxq.pop_front();
      total++; if (rx_data !== exp) begin bad++; $display("FAIL rx_order got=%h want=%h", rx_data, exp); end
      rx_pop = 1; step(); rx_pop = 0;
    end
    total++; if (rx_empty !== 1'b1) begin bad++; $display("FAIL rx_drained got=%b want=1", rx_empty); end
  endtask

  task automatic test_rx_overflow();
    for (int i = 0; i < DEP + 1; i++) begin
      push = 1; D_push = {MY_ID, 8'(i)};
      if (rxq.size() < DEP) rxq.push_back(D_push);
      step();
    end
    push = 0;
    total++; if (rx_ovf !== 1'b1 || rx_count !== 4'd8)
      begin bad++; $display("FAIL rx_ovf got ovf=%b cnt=%0d want 1/8", rx_ovf, rx_count); end
    while (rxq.size() > 0) begin
      total++; if (rx_data !== rxq[0]) begin bad++; $display("FAIL rx_ovf_drain got=%h want=%h", rx_data, rxq[0]); end
      void'(rxq.pop_front());
      rx_pop = 1; step(); rx_pop = 0;
    end
    clr_flags = 1; step(); clr_flags = 0;
  endtask

  task automatic test_underflow();
    pop = 1; step(); pop = 0;
    total++; if (underflow !== 1'b1 || tx_count !== 4'd0 || rx_count !== 4'd0)
      begin bad++; $display("FAIL udf_pop got udf=%b cnt=%0d/%0d want 1/0/0", underflow, tx_count, rx_count); end
    clr_flags = 1; rx_pop = 1; step(); clr_flags = 0; rx_pop = 0;
    total++; if (underflow !== 1'b1) begin bad++; $display("FAIL udf_clr_race got=%b want=1", underflow); end
    clr_flags = 1; step(); clr_flags = 0;
    total++; if (underflow !== 1'b0) begin bad++; $display("FAIL udf_clr got=%b want=0", underflow); end
    // Write and read together on empty: write kept, read ignored.
    tx_push = 1; pop = 1; tx_data = 16'h0777; step(); tx_push = 0; pop = 0;
    total++; if (tx_count !== 4'd1 || D_pop !== 16'h0777 || underflow !== 1'b1)
      begin bad++; $display("FAIL udf_rw_empty got cnt=%0d D_pop=%h udf=%b want 1/0777/1", tx_count, D_pop, underflow); end
    pop = 1; step(); pop = 0;
    clr_flags = 1; step(); clr_flags = 0;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin
      tx_push = 1; tx_data = 16'h0A00 + PSZ'(i); step();
    end
    tx_push = 0;
    total++; if (tx_count !== 4'd5) begin bad++; $display("FAIL mid_fill got=%0d want=5", tx_count); end
    #2 reset = 1'b0;
    #1;
    total++; if (pndng !== 1'b0 || tx_count !== 4'd0)
      begin bad++; $display("FAIL mid_reset got pndng=%b cnt=%0d want 0/0", pndng, tx_count); end
    @(negedge clk);
    reset = 1'b1;
    step();
    total++; if (tx_count !== 4'd0 || pndng !== 1'b0)
      begin bad++; $display("FAIL mid_release got cnt=%0d pndng=%b want 0/0", tx_count, pndng); end
    txq.delete();
  endtask

  task automatic test_back_to_back();
    logic [PSZ-1:0] t, r;
    t = 16'h0100; r = {MY_ID, 8'h00};
    tx_push = 1; tx_data = t; txq.push_back(t);
    push = 1; D_push = r; rxq.push_back(r);
    step();
    for (int i = 1; i <= 20; i++) begin
      t = {8'($urandom_range(0, 255)), 8'(i)};
      r = {MY_ID, 8'($urandom_range(0, 255))};
      total++; if (D_pop !== txq[0]) begin bad++; $display("FAIL wrap_tx%0d got=%h want=%h", i, D_pop, txq[0]); end
      total++; if (rx_data !== rxq[0]) begin bad++; $display("FAIL wrap_rx%0d got=%h want=%h", i, rx_data, rxq[0]); end
      void'(txq.pop_front()); void'(rxq.pop_front());
      tx_push = 1; tx_data = t; txq.push_back(t); pop = 1;
      push = 1; D_push = r; rxq.push_back(r); rx_pop = 1;
      step();
    end
    idle();
    total++; if (tx_count !== 4'd1 || rx_count !== 4'd1)
      begin bad++; $display("FAIL wrap_counts got=%0d/%0d want=1/1", tx_count, rx_count); end
    total++; if (D_pop !== txq[0] || rx_data !== rxq[0])
      begin bad++; $display("FAIL wrap_last got=%h/%h want=%h/%h", D_pop, rx_data, txq[0], rxq[0]); end
    total++; if ({tx_ovf, rx_ovf, underflow, rx_misdir} !== 4'b0000)
      begin bad++; $display("FAIL wrap_flags got=%b want=0000", {tx_ovf, rx_ovf, underflow, rx_misdir}); end
  endtask

  initial begin
    test_reset();
    test_tx_basic();
    test_tx_overflow();
    test_rx_misdir();
    test_rx_overflow();
    test_underflow();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_dev_port.md
# bus_dev_port

Per-device port adapter placed between one device and one port of the `bs_gnrtr_n_rbtr` bus generator/arbiter; one instance per driver index. A transmit FIFO accepts packets from the device and presents them to the arbiter through `pndng`/`D_pop`/`pop`. A receive FIFO captures packets the arbiter delivers through `push`/`D_push` and returns them to the device. Sticky status flags report overflow, underflow and misdirected deliveries.

## Interface
Parameters:
- `pckg_sz`, 16, packet width in bits; bits [pckg_sz-1:pckg_sz-8] are the destination ID.
- `depth`, 8, entries per FIFO; power of two, ≥2.
- `id`, 0, this device's 8-bit ID.
- `broadcast`, 8'hFF, broadcast destination ID.

Ports:
- `clk`  in  1  clock, all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `tx_push`  in  1  device writes `tx_data` into TX FIFO.
- `tx_data`  in  pckg_sz  packet from device.
- `tx_full`  out  1  TX FIFO holds `depth` entries.
- `tx_count`  out  $clog2(depth+1)  TX occupancy.
- `pndng`  out  1  TX FIFO non-empty (to arbiter).
- `D_pop`  out  pckg_sz  TX head packet (to arbiter).
- `pop`  in  1  arbiter consumes TX head.
- `push`  in  1  arbiter delivers `D_push`.
- `D_push`  in  pckg_sz  delivered packet.
- `rx_pop`  in  1  device consumes RX head.
- `rx_data`  out  pckg_sz  RX head packet.
- `rx_empty`  out  1  RX FIFO empty.
- `rx_count`  out  $clog2(depth+1)  RX occupancy.
- `clr_flags`  in  1  synchronous clear of all sticky flags.
- `tx_ovf`, `rx_ovf`, `underflow`, `rx_misdir`  out  1 each  sticky status.

## Operation
- Both FIFOs are first-word-fall-through: head data is valid whenever the FIFO is non-empty. `D_pop`/`rx_data` are don't-care when empty.
- `pndng` = TX count ≠ 0; `rx_empty` = RX count == 0. Both are derived from registered count only, with no combinational path from `pop`/`push`.
- Write when full: accepted only if a read occurs in the same cycle (count unchanged). Otherwise the packet is dropped and `tx_ovf`/`rx_ovf` sets.
- Read when empty: ignored, `underflow` sets. This covers both `pop` and `rx_pop`.
- Simultaneous write and read when empty: the write is stored, the read is ignored, and `underflow` sets.
- Received packet whose dest field ≠ `id` and ≠ `broadcast`: stored anyway, `rx_misdir` sets.
- Sticky flags: set in the cycle of the event and held until `clr_flags`. If `clr_flags` coincides with a new event, the event wins and the flag stays set.
- Pointers are $clog2(depth) bits and wrap modulo `depth`. Count arithmetic uses one extra bit.
- No state machine beyond the FIFO pointer/count registers. The arbiter handshake is level-based: one `pop` cycle consumes exactly one packet.

## Timing
- Reset (`reset`=0, asynchronous): pointers, counts and flags go to 0. Outputs: `pndng`=0, `tx_full`=0, `rx_empty`=1, counts 0, all flags 0, `D_pop`/`rx_data` = 0.
- Reset mid-operation discards all stored packets. Release is synchronous to the first rising edge with `reset`=1.
- `tx_push` sampled at edge N → `pndng`=1 and `D_pop` valid after edge N (cycle N+1). Latency is 1.
- `pop` at edge N → next entry on `D_pop` after edge N. `pndng` falls after edge N if that was the last entry.
- `push` at edge N → `rx_empty`=0 and `rx_data` valid after edge N.
- Back-to-back `pop` every cycle is supported at full throughput. Same for `push`/`tx_push`/`rx_pop`.

## Structure
- Shared package `bus_pkg`:
  - `ID_W`=8.
  - `BROADCAST_ID`=8'hFF.
  - function `get_dest(pkt)` returning the top `ID_W` bits.
- Sub-module `bus_sync_fifo` (params `width`, `depth`), instantiated twice.
  - Ports: wr, wdata, rd, rdata, count, full, empty, ovf_evt, udf_evt.
- Top level holds flag registers and the misdirection compare.

## Test plan
- Reset, then 3 `tx_push` of 16'h0155, 16'h0256, 16'h0357 → `pndng`=1, `D_pop`=16'h0155. Three single `pop`s yield 0155, 0256, 0357 in order, then `pndng`=0.
- With `depth`=8, 9 `tx_push` → `tx_full`=1 after the 8th, 9th packet dropped, `tx_ovf`=1. `tx_push`+`pop` together at full → count stays 8, `tx_ovf` unchanged.
- `id`=2: `push` 16'h02AA, 16'hFF11, 16'h0533 → `rx_count`=3, `rx_misdir`=1 only after the third. `clr_flags` → `rx_misdir`=0.
- `pop` with `pndng`=0 → `underflow`=1, counts unchanged. `clr_flags` and a new `rx_pop` on empty in the same cycle → `underflow` stays 1.
- Fill TX with 5, assert `reset`=0 mid-cycle → `pndng`=0 immediately. After release, `tx_count`=0.
- Wrap test: 20 interleaved push/pop pairs on both FIFOs → data order preserved, no flags set.
